// File: rtl/fuzzy_defuzz_centroid.sv
// rtl/fuzzy_defuzz_centroid.sv - centroid defuzzifier producing a clamped PWM duty from a frame of set degrees
//
// Accepts one frame of NUM_SETS membership degrees (beat k = set k, centre k*STEP),
// accumulates sum(mu*c) and sum(mu), then divides with a bit-serial restoring divider.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_degree/in_last carry a beat this cycle
//   in_ready   block accepts a beat this cycle (ACCUM only)
//   in_degree  degree of the set at the current frame index
//   in_last    final beat of a frame
//   out_valid  single-cycle result strobe
//   out_duty   defuzzified duty, held between results
//   busy       high while dividing or presenting the result
//   err_frame  single-cycle strobe on a frame-length violation
module fuzzy_defuzz_centroid #(
    parameter int NUM_SETS      = 11,
    parameter int DEG_W         = 8,
    parameter int STEP          = 10,
    parameter int DUTY_W        = 8,
    parameter int DUTY_MAX      = 100,
    parameter int ZERO_DEN_DUTY = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DEG_W-1:0]  in_degree,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DUTY_W-1:0] out_duty,
    output logic              busy,
    output logic              err_frame
);

    localparam int NUM_W    = DEG_W + $clog2(STEP * (NUM_SETS - 1) + 1) + $clog2(NUM_SETS);
    localparam int DEN_W    = DEG_W + $clog2(NUM_SETS);
    localparam int IDX_W    = $clog2(NUM_SETS);
    localparam int CNT_W    = $clog2(NUM_W + 1);
    localparam int LAST_IDX = NUM_SETS - 1;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state;
    state_t nextState;

    // Goes high on the first edge after reset so in_ready stays low through reset.
    logic             started;
    logic [IDX_W-1:0] idx;
    // Holds the dividend during accumulation; during DIVIDE the quotient bits
    // are shifted into the bottom while dividend bits leave the top.
    logic [NUM_W-1:0] numAcc;
    logic [DEN_W-1:0] denAcc;
    logic [DEN_W-1:0] rem;
    logic [CNT_W-1:0] divCnt;

    logic             accept;
    logic             atLast;
    logic             violation;
    logic [NUM_W-1:0] product;
    logic [DEN_W:0]   remShift;
    logic [DEN_W:0]   denExt;
    logic             qBit;
    logic [DEN_W:0]   remNext;
    logic [63:0]      dutyWide;

    assign accept    = in_valid && in_ready;
    assign atLast    = (idx == IDX_W'(LAST_IDX));
    // Violation is any disagreement between in_last and the frame position.
    assign violation = accept && (in_last != atLast);
    assign product   = NUM_W'(in_degree) * NUM_W'(idx) * NUM_W'(STEP);

    // One restoring-division step.
    assign remShift = {rem, numAcc[NUM_W-1]};
    assign denExt   = {1'b0, denAcc};
    assign qBit     = (remShift >= denExt);
    assign remNext  = qBit ? (remShift - denExt) : remShift;

    // After NUM_W steps numAcc holds the quotient.
    always_comb begin
        dutyWide = 64'(numAcc);
        if (denAcc == '0) begin
            dutyWide = 64'(ZERO_DEN_DUTY);
        end
        if (dutyWide > 64'(DUTY_MAX)) begin
            dutyWide = 64'(DUTY_MAX);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ACCUM: begin
                if (accept && atLast && in_last) begin
                    nextState = DIVIDE;
                end
            end
            DIVIDE: begin
                if (divCnt == CNT_W'(NUM_W - 1)) begin
                    nextState = OUTPUT;
                end
            end
            OUTPUT:  nextState = ACCUM;
            default: nextState = ACCUM;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            ACCUM:   in_ready = started;
            DIVIDE:  busy = 1'b1;
            OUTPUT:  busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started   <= 1'b0;
            idx       <= '0;
            numAcc    <= '0;
            denAcc    <= '0;
            rem       <= '0;
            divCnt    <= '0;
            out_valid <= 1'b0;
            out_duty  <= '0;
            err_frame <= 1'b0;
        end else begin
            started   <= 1'b1;
            out_valid <= 1'b0;
            err_frame <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (violation) begin
                            idx       <= '0;
                            numAcc    <= '0;
                            denAcc    <= '0;
                            err_frame <= 1'b1;
                        end else begin
                            numAcc <= numAcc + product;
                            denAcc <= denAcc + DEN_W'(in_degree);
                            if (atLast) begin
                                idx    <= '0;
                                rem    <= '0;
                                divCnt <= '0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                DIVIDE: begin
                    numAcc <= {numAcc[NUM_W-2:0], qBit};
                    rem    <= DEN_W'(remNext);
                    divCnt <= divCnt + CNT_W'(1);
                end
                OUTPUT: begin
                    out_duty  <= DUTY_W'(dutyWide);
                    out_valid <= 1'b1;
                    idx       <= '0;
                    numAcc    <= '0;
                    denAcc    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_defuzz_centroid.sv
// tb/tb_fuzzy_defuzz_centroid.sv - self-checking bench for fuzzy_defuzz_centroid
module tb_fuzzy_defuzz_centroid;

    localparam int NS = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_degree = 8'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic [7:0] out_duty;
    logic       busy;
    logic       err_frame;

    int errors = 0;
    int checks = 0;
    int degs[NS];
    int lastDuty = 0;

    always #5 clk = ~clk;

    fuzzy_defuzz_centroid dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_degree (in_degree),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_duty  (out_duty),
        .busy      (busy),
        .err_frame (err_frame)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Weighted average of the centres k*10, clamped to 100; 50 for an empty frame.
    function automatic int modelDuty();
        int num = 0;
        int den = 0;
        int q;
        for (int k = 0; k < NS; k++) begin
            num += degs[k] * k * 10;
            den += degs[k];
        end
        if (den == 0) return 50;
        q = num / den;
        if (q > 100) q = 100;
        return q;
    endfunction

    task automatic clearDegs();
        for (int k = 0; k < NS; k++) degs[k] = 0;
    endtask

    task automatic sendBeat(input int deg, input logic last);
        int waitN;
        logic [31:0] d;
        d = deg;
        @(negedge clk);
        in_valid  = 1'b1;
        in_degree = d[7:0];
        in_last   = last;
        waitN = 0;
        while (!in_ready && waitN < 50) begin
            @(negedge clk);
            waitN++;
        end
        if (waitN >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // lastAt: index carrying in_last (NS-1 normal, smaller = early last, -1 = never).
    task automatic sendFrame(input bit gaps, input int lastAt);
        for (int k = 0; k < NS; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
            sendBeat(degs[k], k == lastAt);
            if (k == lastAt) break;
        end
    endtask

    task automatic checkResult(input string tag);
        int exp;
        int lat;
        exp = modelDuty();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_notready"}, 32'(in_ready), 32'd0);
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd20);
        chk({tag, "_duty"}, 32'(out_duty), 32'(exp));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
        chk({tag, "_hold"}, 32'(out_duty), 32'(exp));
        lastDuty = exp;
    endtask

    task automatic checkNoResult(input string tag);
        int seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        chk({tag, "_no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_duty", 32'(out_duty), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_frame), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // Singleton
        clearDegs();
        degs[6] = 200;
        sendFrame(1'b0, NS - 1);
        checkResult("singleton");
        chk("singleton_60", 32'(lastDuty), 32'd60);

        // Blend
        clearDegs();
        degs[1] = 100;
        degs[2] = 100;
        sendFrame(1'b1, NS - 1);
        checkResult("blend");

        // Truncation
        clearDegs();
        degs[0]  = 255;
        degs[10] = 85;
        sendFrame(1'b0, NS - 1);
        checkResult("trunc_a");
        clearDegs();
        degs[3] = 3;
        degs[4] = 1;
        sendFrame(1'b1, NS - 1);
        checkResult("trunc_b");

        // All zero
        clearDegs();
        sendFrame(1'b0, NS - 1);
        checkResult("zero_den");

        // Early in_last on beat 5
        for (int k = 0; k < NS; k++) degs[k] = $urandom_range(0, 255);
        sendFrame(1'b0, 5);
        chk("early_err", 32'(err_frame), 32'd1);
        @(posedge clk);
        #1;
        chk("early_err_pulse", 32'(err_frame), 32'd0);
        checkNoResult("early");
        chk("early_duty_kept", 32'(out_duty), 32'(lastDuty));
        clearDegs();
        degs[9] = 7;
        degs[2] = 21;
        sendFrame(1'b0, NS - 1);
        checkResult("after_early");

        // Missing in_last on beat NS-1
        for (int k = 0; k < NS; k++) degs[k] = $urandom_range(0, 255);
        sendFrame(1'b1, -1);
        chk("late_err", 32'(err_frame), 32'd1);
        checkNoResult("late");
        chk("late_duty_kept", 32'(out_duty), 32'(lastDuty));
        sendFrame(1'b0, NS - 1);
        checkResult("after_late");

        // Random frames, some sparse
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < NS; k++) begin
                degs[k] = ($urandom_range(0, 3) == 0 || f < 4) ? $urandom_range(0, 255) : 0;
            end
            sendFrame(f[0], NS - 1);
            checkResult("random");
        end

        // Reset in the middle of DIVIDE
        for (int k = 0; k < NS; k++) degs[k] = $urandom_range(1, 255);
        sendFrame(1'b0, NS - 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_duty", 32'(out_duty), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready_back", 32'(in_ready), 32'd1);
        checkNoResult("mid_rst");
        chk("mid_rst_duty_hold", 32'(out_duty), 32'd0);
        for (int k = 0; k < NS; k++) degs[k] = $urandom_range(0, 255);
        sendFrame(1'b1, NS - 1);
        checkResult("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fuzzy_defuzz_centroid.md
FUZZY_DEFUZZ_CENTROID -- requirements
Module: fuzzy_defuzz_centroid

Interface
REQ-001 The block SHALL use a single clock domain and a synchronous, active-low reset.
REQ-002 Parameter NUM_SETS, default 11: number of output fuzzy sets; legal range 2..32.
REQ-003 Parameter DEG_W, default 8: width of each membership degree.
REQ-004 Parameter STEP, default 10: singleton centre spacing; set i has centre c_i = i*STEP.
REQ-005 Parameter DUTY_W, default 8: width of out_duty.
REQ-006 Parameter DUTY_MAX, default 100: ceiling applied to out_duty.
REQ-007 Parameter ZERO_DEN_DUTY, default 50: duty reported when all degrees are zero.
REQ-008 Port clk, input, 1 bit: rising-edge clock.
REQ-009 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-010 Port in_valid, input, 1 bit: in_degree is valid this cycle.
REQ-011 Port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-012 Port in_degree, input, DEG_W bits: degree of the set at the current frame index.
REQ-013 Port in_last, input, 1 bit: marks the final beat of a frame.
REQ-014 Port out_valid, output, 1 bit: single-cycle result strobe.
REQ-015 Port out_duty, output, DUTY_W bits: defuzzified PWM duty, held between results.
REQ-016 Port busy, output, 1 bit: high in the DIVIDE and OUTPUT states.
REQ-017 Port err_frame, output, 1 bit: single-cycle strobe on frame-length violation.

Function
REQ-018 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-019 Frame structure: exactly NUM_SETS beats; beat k carries the degree of set k, k = 0..NUM_SETS-1; the index comes from an internal counter.
REQ-020 Accumulation: each accepted beat adds mu_k*c_k to NUM and mu_k to DEN, with no overflow.
- NUM width NUM_W = DEG_W + clog2(STEP*(NUM_SETS-1)+1) + clog2(NUM_SETS); this is 19 at defaults.
- DEN width = DEG_W + clog2(NUM_SETS).
REQ-021 FSM states SHALL be ACCUM, DIVIDE and OUTPUT; the reset state is ACCUM with index 0 and NUM = DEN = 0.
REQ-022 ACCUM SHALL drive in_ready=1.
- If the accepted beat has index NUM_SETS-1 and in_last=1, the FSM goes to DIVIDE.
REQ-023 Frame-length violation: either condition below is a violation.
- in_last=1 on an accepted beat with index < NUM_SETS-1.
- in_last=0 on an accepted beat with index NUM_SETS-1.
- Response: err_frame pulses 1 cycle, NUM, DEN and index clear, the FSM stays in ACCUM, out_valid is not asserted, and out_duty is unchanged.
REQ-024 DIVIDE SHALL drive in_ready=0 and compute floor(NUM/DEN) by restoring division, one quotient bit per cycle, for NUM_W cycles.
REQ-025 Zero denominator: if DEN=0, the DIVIDE state SHALL still last NUM_W cycles, and the result is ZERO_DEN_DUTY.
REQ-026 The result SHALL be clamped to DUTY_MAX and zero-extended or truncated to DUTY_W.
REQ-027 OUTPUT SHALL last 1 cycle and drive in_ready=0.
- out_duty is registered from the result, out_valid=1 for that cycle, and the FSM returns to ACCUM with the accumulators cleared.
REQ-028 Latency: out_valid SHALL assert exactly NUM_W+1 clock edges after the edge that accepts the last beat; this is 20 cycles at defaults.
REQ-029 Throughput: in_valid is don't-care while in_ready=0; a new frame can be accepted on the cycle after out_valid.
REQ-030 Gaps: idle cycles within a frame (in_valid=0) SHALL NOT advance the index or alter the accumulators.
REQ-031 out_duty SHALL change only in OUTPUT and hold its value otherwise.

Reset
REQ-032 While rst_n=0 at a clock edge, the outputs SHALL be: in_ready=0, out_valid=0, out_duty=0, busy=0, err_frame=0.
- The FSM goes to ACCUM, and index, NUM, DEN and divider state are cleared.
REQ-033 Reset asserted in any state, including mid-DIVIDE, SHALL abort the computation with no out_valid.
REQ-034 in_ready SHALL rise on the first edge with rst_n=1.

Verification (defaults)
REQ-035 Singleton: set 6 degree 200, all others 0 -> out_duty=60 with a 1-cycle out_valid 20 cycles after the last beat.
REQ-036 Blend: set 1=100, set 2=100, others 0 -> out_duty=15.
REQ-037 Truncation: set 0=255, set 10=85, others 0 -> 8500/340 gives out_duty=25; then set 3=3, set 4=1 -> 130/4 truncates to 32.
REQ-038 All degrees 0 -> out_duty=50 and out_valid asserted.
REQ-039 Violation: in_last on beat 5 -> err_frame pulses 1 cycle, no out_valid, out_duty unchanged; a following correct frame yields the correct result.
REQ-040 Reset mid-DIVIDE with rst_n low for 1 cycle -> out_valid never asserts, out_duty=0, and in_ready=1 on the next edge.
